// File: rtl/reg_bank_rwsc.sv
// Register bank on the Sir bus with per-register RW, RWSC, W1C and RO modes.
// Define REG_BANK_IRQ_EN to add an interrupt mask register at BASEADDR+NREGS.
module reg_bank_rwsc #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter int NREGS = 8,
  parameter logic [ADDRWIDTH-1:0] BASEADDR = 8'h00,
  parameter logic [NREGS*DATAWIDTH-1:0] INITVALUE = '0,
  parameter logic [2*NREGS-1:0] MODE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic SirSel,
  input  logic SirRead,
  input  logic [ADDRWIDTH-1:0] SirAddr,
  input  logic [DATAWIDTH-1:0] SirWdat,
  output logic SirDack,
  output logic [DATAWIDTH-1:0] SirRdat,
  input  logic [NREGS-1:0] Clr,
  input  logic [NREGS*DATAWIDTH-1:0] HwIn,
  output logic [NREGS*DATAWIDTH-1:0] Q,
  output logic [NREGS-1:0] WrStb,
  output logic Irq
);

  localparam int AW1 = ADDRWIDTH + 1;
  localparam logic [AW1-1:0] LO = {1'b0, BASEADDR};
  localparam logic [AW1-1:0] HI = LO + AW1'(NREGS);

  localparam logic [1:0] M_RW   = 2'd0;
  localparam logic [1:0] M_RWSC = 2'd1;
  localparam logic [1:0] M_W1C  = 2'd2;

  logic s1;
  logic s2;
  logic [AW1-1:0] addr;
  logic [AW1-1:0] off;
  logic in_rng;
  logic hit;
  logic first;
  logic wr_ev;
  logic any_hit;
  logic [NREGS-1:0] wr_sel;
  logic [DATAWIDTH-1:0] rd_mux;
  logic [DATAWIDTH-1:0] rd_val;
  logic [NREGS*DATAWIDTH-1:0] q;
  logic [NREGS-1:0] stb;
  logic dack;
  logic [DATAWIDTH-1:0] rdat;
  logic irq;

  assign addr   = {1'b0, SirAddr};
  assign off    = addr - LO;
  assign in_rng = (addr >= LO) && (addr < HI);
  assign hit    = SirSel & in_rng;
  assign first  = s1 & ~s2 & ~SirRead;
  assign wr_ev  = first & hit;

  // Per-register write select and read-data mux from the address offset
  always_comb begin
    wr_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (off == AW1'(i)) begin
        wr_sel[i] = wr_ev;
        rd_mux = q[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

`ifdef REG_BANK_IRQ_EN
  logic mhit;
  logic mwr;
  logic [DATAWIDTH-1:0] mask;
  logic irq_nx;

  assign mhit    = SirSel & (addr == HI);
  assign mwr     = first & mhit;
  assign any_hit = hit | mhit;
  assign rd_val  = mhit ? mask : rd_mux;

  // Interrupt source: masked bits of every W1C register
  always_comb begin
    irq_nx = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (MODE[2*i +: 2] == M_W1C)
        irq_nx = irq_nx | (|(q[i*DATAWIDTH +: DATAWIDTH] & mask));
    end
  end

  // Mask register and registered interrupt output
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (mwr)
        mask <= SirWdat;
      irq <= irq_nx;
    end
  end
`else
  assign any_hit = hit;
  assign rd_val  = rd_mux;
  assign irq     = 1'b0;
`endif

  // Select edge detect, acknowledge and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      dack <= 1'b0;
      rdat <= '0;
    end else begin
      s1   <= SirSel;
      s2   <= s1;
      dack <= any_hit;
      rdat <= (any_hit & SirRead) ? rd_val : '0;
    end
  end

  // Register contents by mode, plus write strobe aligned with the update
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= INITVALUE;
      stb <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        unique case (MODE[2*i +: 2])
          M_RW: begin
            stb[i] <= wr_sel[i];
            if (wr_sel[i])
              q[i*DATAWIDTH +: DATAWIDTH] <= SirWdat;
          end
          M_RWSC: begin
            stb[i] <= wr_sel[i];
            if (Clr[i])
              q[i*DATAWIDTH +: DATAWIDTH] <=
                INITVALUE[i*DATAWIDTH +: DATAWIDTH];
            else if (wr_sel[i])
              q[i*DATAWIDTH +: DATAWIDTH] <= SirWdat;
          end
          M_W1C: begin
            stb[i] <= wr_sel[i];
            q[i*DATAWIDTH +: DATAWIDTH] <=
              (q[i*DATAWIDTH +: DATAWIDTH] &
               ~(wr_sel[i] ? SirWdat : '0)) |
              HwIn[i*DATAWIDTH +: DATAWIDTH];
          end
          default: begin
            stb[i] <= 1'b0;
            q[i*DATAWIDTH +: DATAWIDTH] <=
              HwIn[i*DATAWIDTH +: DATAWIDTH];
          end
        endcase
      end
    end
  end

  assign Q       = q;
  assign WrStb   = stb;
  assign SirDack = dack;
  assign SirRdat = rdat;
  assign Irq     = irq;

endmodule

// File: tb/tb_reg_bank_rwsc.sv
// Scoreboard bench for reg_bank_rwsc: 4 regs (RW, RWSC, W1C, RO) at 8'h10.
// Build with REG_BANK_IRQ_EN to cover the mask register and interrupt.
module tb_reg_bank_rwsc;

`ifdef REG_BANK_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SirSel = 1'b0;
  logic SirRead = 1'b0;
  logic [7:0] SirAddr = '0;
  logic [7:0] SirWdat = '0;
  logic SirDack;
  logic [7:0] SirRdat;
  logic [3:0] Clr = '0;
  logic [31:0] HwIn = '0;
  logic [31:0] Q;
  logic [3:0] WrStb;
  logic Irq;

  reg_bank_rwsc #(
    .ADDRWIDTH(8),
    .DATAWIDTH(8),
    .NREGS(4),
    .BASEADDR(8'h10),
    .INITVALUE(32'h0),
    .MODE(8'b11_10_01_00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SirSel(SirSel),
    .SirRead(SirRead),
    .SirAddr(SirAddr),
    .SirWdat(SirWdat),
    .SirDack(SirDack),
    .SirRdat(SirRdat),
    .Clr(Clr),
    .HwIn(HwIn),
    .Q(Q),
    .WrStb(WrStb),
    .Irq(Irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] m_q [4];
  logic [7:0] m_mask;
  logic [7:0] hw [4];
  int m_stb [4];
  int stb_cnt [4];
  logic [7:0] exp_q [$];
  bit prev_dack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Count write strobe cycles per register
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (WrStb[i] === 1'b1) stb_cnt[i]++;
  end

  // Scoreboard monitor: each acknowledge rise pops one expected read value
  always @(negedge clk) begin
    logic [7:0] e;
    if (SirDack === 1'b1 && !prev_dack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dack", {31'b0, SirDack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rdat", {24'b0, SirRdat}, {24'b0, e});
      end
    end
    prev_dack = (SirDack === 1'b1);
  end

  task automatic set_hw(input int i, input logic [7:0] v);
    hw[i] = v;
    HwIn[i*8 +: 8] = v;
  endtask

  task automatic check_all();
    logic exp_irq;
    exp_irq = IRQ ? |(m_q[2] & m_mask) : 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("q%0d", i), {24'b0, Q[i*8 +: 8]}, {24'b0, m_q[i]});
      chk($sformatf("stb_cnt%0d", i), stb_cnt[i], m_stb[i]);
    end
    chk("irq", {31'b0, Irq}, {31'b0, exp_irq});
  endtask

  // Let hardware inputs propagate, update the model, compare everything
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    m_q[2] = m_q[2] | hw[2];
    m_q[3] = hw[3];
    check_all();
  endtask

  task automatic access(input logic [7:0] addr, input bit rd,
                        input logic [7:0] w, input int hold,
                        input logic [3:0] clr_wr);
    int idx;
    bit hit;
    idx = int'(addr) - 16;
    hit = (idx >= 0 && idx < 4) || (IRQ && idx == 4);
    if (hit)
      exp_q.push_back(rd ? (idx == 4 ? m_mask : m_q[idx]) : 8'h00);
    @(posedge clk);
    #1;
    SirSel = 1'b1;
    SirAddr = addr;
    SirRead = rd;
    SirWdat = w;
    @(posedge clk);
    #1;
    Clr = clr_wr;
    @(negedge clk);
    chk("dack_first", {31'b0, SirDack}, {31'b0, hit});
    if (!hit) chk("rdat_miss", {24'b0, SirRdat}, 32'd0);
    for (int k = 2; k <= hold; k++) begin
      @(posedge clk);
      #1;
      Clr = '0;
      chk("dack_hold", {31'b0, SirDack}, {31'b0, hit});
    end
    SirSel = 1'b0;
    if (hit && !rd) begin
      case (idx)
        0: begin m_q[0] = w; m_stb[0]++; end
        1: begin m_q[1] = w; m_stb[1]++; end
        2: begin m_q[2] = (m_q[2] & ~w) | hw[2]; m_stb[2]++; end
        4: m_mask = w;
        default: ;
      endcase
    end
    if (clr_wr[1]) m_q[1] = 8'h00;
  endtask

  task automatic clr_pulse(input logic [3:0] v);
    @(posedge clk);
    #1;
    Clr = v;
    @(posedge clk);
    #1;
    Clr = '0;
    if (v[1]) m_q[1] = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      m_q[i] = '0;
      hw[i] = '0;
      m_stb[i] = 0;
    end
    m_mask = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", Q, 32'h0);
    chk("rst_dack", {31'b0, SirDack}, 32'd0);
    chk("rst_rdat", {24'b0, SirRdat}, 32'd0);
    chk("rst_stb", {28'b0, WrStb}, 32'd0);
    chk("rst_irq", {31'b0, Irq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle();

    // Long select: single write, single strobe; then read back
    access(8'h10, 1'b0, 8'hA5, 5, 4'b0);
    settle();
    chk("q0_a5", {24'b0, Q[7:0]}, 32'hA5);
    access(8'h10, 1'b1, 8'h00, 3, 4'b0);
    settle();

    // RWSC: write, then clear wins over simultaneous write
    access(8'h11, 1'b0, 8'h3C, 2, 4'b0);
    settle();
    chk("q1_3c", {24'b0, Q[15:8]}, 32'h3C);
    access(8'h11, 1'b0, 8'hFF, 2, 4'b0010);
    settle();
    chk("q1_clr", {24'b0, Q[15:8]}, 32'h00);

    // W1C: hardware set beats write-1-clear
    set_hw(2, 8'h81);
    settle();
    set_hw(2, 8'h01);
    settle();
    access(8'h12, 1'b0, 8'h01, 2, 4'b0);
    settle();
    chk("q2_81", {24'b0, Q[23:16]}, 32'h81);
    set_hw(2, 8'h00);
    settle();
    access(8'h12, 1'b0, 8'h01, 2, 4'b0);
    settle();
    chk("q2_80", {24'b0, Q[23:16]}, 32'h80);

    // RO: write acknowledged but ignored; out-of-range not acknowledged
    set_hw(3, 8'h5A);
    settle();
    access(8'h13, 1'b0, 8'hFF, 2, 4'b0);
    settle();
    chk("q3_5a", {24'b0, Q[31:24]}, 32'h5A);
    access(8'h15, 1'b1, 8'h00, 2, 4'b0);
    settle();

`ifdef REG_BANK_IRQ_EN
    access(8'h14, 1'b0, 8'h80, 2, 4'b0);
    settle();
    set_hw(2, 8'h80);
    settle();
    chk("irq_set", {31'b0, Irq}, 32'd1);
    set_hw(2, 8'h00);
    settle();
    access(8'h12, 1'b0, 8'h80, 2, 4'b0);
    settle();
    chk("irq_clr", {31'b0, Irq}, 32'd0);
`else
    access(8'h14, 1'b0, 8'h80, 2, 4'b0);
    settle();
`endif

    // Reset in the middle of a write with select held high
    set_hw(2, 8'h00);
    set_hw(3, 8'h00);
    settle();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    SirSel = 1'b1;
    SirAddr = 8'h10;
    SirRead = 1'b0;
    SirWdat = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_q", Q, 32'h0);
    chk("mid_rst_dack", {31'b0, SirDack}, 32'd0);
    chk("mid_rst_rdat", {24'b0, SirRdat}, 32'd0);
    chk("mid_rst_stb", {28'b0, WrStb}, 32'd0);
    chk("mid_rst_irq", {31'b0, Irq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_q[i] = '0;
    m_mask = '0;
    repeat (4) @(posedge clk);
    #1;
    SirSel = 1'b0;
    m_q[0] = 8'h77;
    m_stb[0]++;
    settle();

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        set_hw(2, ($urandom_range(0, 1) == 0) ? 8'h00 :
                  8'($urandom & $urandom & $urandom));
      if ($urandom_range(0, 3) == 0)
        set_hw(3, 8'($urandom));
      if ($urandom_range(0, 3) == 0)
        set_hw($urandom_range(0, 1), 8'($urandom));
      if ($urandom_range(0, 4) == 0)
        clr_pulse(4'($urandom));
      settle();
      a = ($urandom_range(0, 9) == 0) ? 8'h0F :
          8'(8'h10 + $urandom_range(0, 6));
      access(a, 1'($urandom_range(0, 1)), 8'($urandom),
             $urandom_range(2, 5),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0);
      settle();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_rwsc.md
REG_BANK_RWSC -- requirements
Module: reg_bank_rwsc

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 8: SirAddr width.
REQ-002 SHALL have parameter DATAWIDTH, default 32: register width.
REQ-003 SHALL have parameter NREGS, default 8: register count, 1..64.
REQ-004 SHALL have parameter BASEADDR, default 8'h00: address of register 0; register i is at BASEADDR+i.
REQ-005 SHALL have parameter INITVALUE, default all zeros, NREGS*DATAWIDTH bits: per-register reset and clear value.
REQ-006 SHALL have parameter MODE, default all zeros, 2*NREGS bits, selecting per-register mode: 0 RW, 1 RWSC, 2 W1C, 3 RO.
REQ-007 SHALL have port clk, input, 1 bit: clock.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have ports SirSel (input, 1: access select), SirRead (input, 1: 1 read, 0 write) and SirAddr (input, ADDRWIDTH: address).
REQ-010 SHALL have ports SirWdat (input, DATAWIDTH: write data), SirDack (output, 1: access acknowledge) and SirRdat (output, DATAWIDTH: read data).
REQ-011 SHALL have port Clr, input, NREGS bits: per-register hardware clear, used by RWSC registers.
REQ-012 SHALL have port HwIn, input, NREGS*DATAWIDTH bits: W1C set bits, or RO value.
REQ-013 SHALL have ports Q (output, NREGS*DATAWIDTH: register contents) and WrStb (output, NREGS: one-cycle write pulse).
REQ-014 SHALL have port Irq, output, 1 bit: interrupt.

Function
REQ-015 SHALL decode hit = SirSel & (BASEADDR <= SirAddr < BASEADDR+NREGS), with index = SirAddr-BASEADDR.
REQ-016 SHALL register SirSel twice (s1, s2); write event = s1 & ~s2 & hit & ~SirRead, so exactly one write per SirSel assertion, committed on the 2nd clk edge after SirSel rises.
REQ-017 SHALL drive SirDack 1 on the cycle after any hit and keep it 1 while the hit persists; SHALL drive 0 for out-of-range addresses.
REQ-018 SHALL register SirRdat = Q[index] on the cycle after hit & SirRead, and drive 0 otherwise.
REQ-019 RW registers: write loads SirWdat; Clr ignored.
REQ-020 RWSC registers: Clr loads INITVALUE; a write loads SirWdat; Clr has priority over a simultaneous write.
REQ-021 W1C registers: Q <= (Q & ~(write ? SirWdat : 0)) | HwIn every cycle; hardware set wins over write-1-clear on the same bit.
REQ-022 RO registers: Q <= HwIn every cycle; writes are ignored but still acknowledged; WrStb stays 0.
REQ-023 WrStb[i] SHALL pulse 1 cycle, coincident with the Q update, for each committed write to a non-RO register.
REQ-024 Accesses SHALL not disturb unaddressed registers; a write to index i SHALL not change Q[j] for j != i.

Reset
REQ-025 On rst, Q SHALL load INITVALUE; SirDack, SirRdat, WrStb, Irq, s1, s2 and the mask SHALL go to 0.
REQ-026 Reset mid-access SHALL abort it; if SirSel is still high after rst falls, one write to the current SirAddr SHALL occur 2 edges later.

Configuration
REQ-027 With REG_BANK_IRQ_EN defined, an RW mask register SHALL exist at BASEADDR+NREGS, reset 0, and Irq SHALL be registered OR over W1C registers of (Q & mask), updating 1 cycle after Q.
REQ-028 Without REG_BANK_IRQ_EN, Irq SHALL be constant 0 and BASEADDR+NREGS SHALL be unmapped (no SirDack, SirRdat 0).

Verification (NREGS=4, DATAWIDTH=8, BASEADDR=8'h10, MODE reg0..3 = RW, RWSC, W1C, RO, INITVALUE 0)
REQ-029 Write 8'hA5 to 8'h10 with SirSel held 5 cycles -> Q0=A5 exactly once; WrStb[0] is a single pulse; read of 8'h10 returns A5 with SirDack=1.
REQ-030 Write 8'h3C to 8'h11, then Clr[1] in the same cycle as a second write of 8'hFF -> Q1=3C, then Q1=00.
REQ-031 HwIn2=8'h81, then write 8'h01 to 8'h12 while HwIn2=8'h01 -> Q2 stays 81; with HwIn2=0, the same write gives Q2=80.
REQ-032 HwIn3=8'h5A, write 8'hFF to 8'h13 -> Q3=5A, SirDack=1, WrStb[3]=0; access to 8'h15 -> SirDack=0, SirRdat=0.
REQ-033 With REG_BANK_IRQ_EN: mask 8'h80 at 8'h14, HwIn2=8'h80 -> Irq=1; write 8'h80 to 8'h12 -> Irq=0; without the macro, Irq=0 throughout.
REQ-034 Assert rst mid-write with SirSel high -> all outputs reset; exactly one write commits after release.
